// File: rtl/cond_unit_banked.sv
// -----------------------------------------------------------------------------
// cond_unit_banked
//
// Condition unit for the single-cycle core. It keeps the architectural NZCV
// flags in NUM_BANKS banks and checks the instruction condition field against
// the active bank. It then gates the decoder's PC-source, register-write and
// memory-write requests. On an executed instruction it updates the flags in
// two independent groups: {N,Z} and {C,V}.
//
// Optional feature: define CLU_PERF_CNT_EN to build two saturating
// performance counters (executed / squashed instructions). When the macro is
// undefined, the counter ports are tied to zero and cnt_clr is ignored.
//
// Parameters
//   NUM_BANKS  number of NZCV flag banks (>=1)
//   CNT_W      width of the performance counters
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (all banks and counters to 0)
//   en         instruction valid / not stalled; 0 holds all state
//   cond       instruction condition field
//   alu_flags  {N,Z,C,V} produced by the ALU this cycle
//   flag_w     [1] update N,Z ; [0] update C,V
//   pcs        decoder PC-source request
//   reg_w      decoder register-write request
//   mem_w      decoder memory-write request
//   no_write   compare-class instruction, suppresses register write
//   bank_sel   active flag bank (clamped to NUM_BANKS-1)
//   cond_ex    condition passed for the current instruction
//   pcs_o      gated PC-source
//   reg_w_o    gated register write
//   mem_w_o    gated memory write
//   flags_o    registered {N,Z,C,V} of the active bank
//   cnt_clr    synchronous clear of both counters
//   exec_cnt   executed-instruction count
//   squash_cnt squashed-instruction count
//
// Handshake: en acts as the valid qualifier for the instruction that is
// presented this cycle. There is no ready; the unit always accepts. An
// instruction with en=0 has no side effects and produces no gated requests.
// -----------------------------------------------------------------------------
module cond_unit_banked #(
    parameter  int NUM_BANKS = 2,
    parameter  int CNT_W     = 16,
    localparam int BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       cond,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    input  logic [BW-1:0]    bank_sel,
    output logic             cond_ex,
    output logic             pcs_o,
    output logic             reg_w_o,
    output logic             mem_w_o,
    output logic [3:0]       flags_o,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    logic [3:0]    bank_q [NUM_BANKS];
    logic [BW-1:0] act_bank;
    logic [3:0]    cur_flags;
    logic          f_n, f_z, f_c, f_v;
    logic          wr_nz, wr_cv;

    // Out-of-range selects fall back to the last bank so that reads and
    // writes always address the same, existing bank.
    always_comb begin
        act_bank = '0;
        if (NUM_BANKS > 1) begin
            if ({1'b0, bank_sel} >= (BW+1)'(NUM_BANKS))
                act_bank = BW'(NUM_BANKS - 1);
            else
                act_bank = bank_sel;
        end
    end

    // Flags are always the registered state of earlier instructions. The
    // ALU result of this cycle does not bypass into cond_ex.
    assign cur_flags = bank_q[act_bank];
    assign f_n       = cur_flags[3];
    assign f_z       = cur_flags[2];
    assign f_c       = cur_flags[1];
    assign f_v       = cur_flags[0];
    assign flags_o   = cur_flags;

    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            4'h0:    cond_ex = f_z;
            4'h1:    cond_ex = ~f_z;
            4'h2:    cond_ex = f_c;
            4'h3:    cond_ex = ~f_c;
            4'h4:    cond_ex = f_n;
            4'h5:    cond_ex = ~f_n;
            4'h6:    cond_ex = f_v;
            4'h7:    cond_ex = ~f_v;
            4'h8:    cond_ex = f_c & ~f_z;
            4'h9:    cond_ex = ~f_c | f_z;
            4'hA:    cond_ex = (f_n == f_v);
            4'hB:    cond_ex = (f_n != f_v);
            4'hC:    cond_ex = ~f_z & (f_n == f_v);
            4'hD:    cond_ex = f_z | (f_n != f_v);
            // AL, and the unused 0xF encoding, both execute unconditionally.
            default: cond_ex = 1'b1;
        endcase
    end

    assign pcs_o   = pcs & cond_ex & en;
    assign reg_w_o = reg_w & cond_ex & ~no_write & en;
    assign mem_w_o = mem_w & cond_ex & en;

    assign wr_nz = en & cond_ex & flag_w[1];
    assign wr_cv = en & cond_ex & flag_w[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++)
                bank_q[b] <= 4'b0000;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (BW'(b) == act_bank) begin
                    if (wr_nz) bank_q[b][3:2] <= alu_flags[3:2];
                    if (wr_cv) bank_q[b][1:0] <= alu_flags[1:0];
                end
            end
        end
    end

`ifdef CLU_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] exec_q;
    logic [CNT_W-1:0] squash_q;

    // The clear wins over a same-cycle increment. Both counters stick at
    // their maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else if (cnt_clr) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else if (en) begin
            if (cond_ex && (exec_q != CNT_MAX))
                exec_q <= exec_q + 1'b1;
            if (!cond_ex && (squash_q != CNT_MAX))
                squash_q <= squash_q + 1'b1;
        end
    end

    assign exec_cnt   = exec_q;
    assign squash_cnt = squash_q;
`else
    // The counter ports stay in place so the interface does not change
    // between builds.
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign exec_cnt       = '0;
    assign squash_cnt     = '0;
`endif

endmodule

// File: tb/tb_cond_unit_banked.sv
// -----------------------------------------------------------------------------
// tb_cond_unit_banked
//
// Bench for cond_unit_banked (NUM_BANKS=2, CNT_W=4). A behavioural model holds
// one flag nibble per bank and two integer counters. A single compare process
// checks every DUT output against that model on each falling edge. Directed
// sections add hand-computed literal expectations, and a random section
// exercises mixed traffic at the end.
// -----------------------------------------------------------------------------
module tb_cond_unit_banked;

    localparam int NB    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst_n;
    always #5 if (clk_run) clk = ~clk;

    logic          en, pcs, reg_w, mem_w, no_write, bank_sel, cnt_clr;
    logic [3:0]    cond, alu_flags;
    logic [1:0]    flag_w;
    logic          cond_ex, pcs_o, reg_w_o, mem_w_o;
    logic [3:0]    flags_o;
    logic [CW-1:0] exec_cnt, squash_cnt;

    cond_unit_banked #(.NUM_BANKS(NB), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .cond(cond), .alu_flags(alu_flags),
        .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w),
        .no_write(no_write), .bank_sel(bank_sel), .cond_ex(cond_ex),
        .pcs_o(pcs_o), .reg_w_o(reg_w_o), .mem_w_o(mem_w_o), .flags_o(flags_o),
        .cnt_clr(cnt_clr), .exec_cnt(exec_cnt), .squash_cnt(squash_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic chk_on = 1'b0;
    logic [3:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each code pair shares one base predicate; the odd member is its
    // negation, except for pair 7 (AL and 0xF), which always passes.
    function automatic bit model_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    logic [3:0] m_flags [NB];
    int m_exec, m_squash;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NB; b++) m_flags[b] = 4'h0;
            m_exec = 0;
            m_squash = 0;
        end else begin
            bit p;
            p = model_pass(cond, m_flags[bank_sel]);
            if (en && p) begin
                if (flag_w[1]) m_flags[bank_sel][3:2] = alu_flags[3:2];
                if (flag_w[0]) m_flags[bank_sel][1:0] = alu_flags[1:0];
            end
`ifdef CLU_PERF_CNT_EN
            if (cnt_clr) begin
                m_exec = 0;
                m_squash = 0;
            end else if (en) begin
                if (p) m_exec = (m_exec < CMAX) ? m_exec + 1 : CMAX;
                else   m_squash = (m_squash < CMAX) ? m_squash + 1 : CMAX;
            end
`endif
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            bit p;
            p = model_pass(cond, m_flags[bank_sel]);
            chk("cond_ex", 32'(cond_ex), 32'(p));
            chk("pcs_o", 32'(pcs_o), 32'(pcs && p && en));
            chk("reg_w_o", 32'(reg_w_o), 32'(reg_w && p && !no_write && en));
            chk("mem_w_o", 32'(mem_w_o), 32'(mem_w && p && en));
            chk("flags_o", 32'(flags_o), 32'(m_flags[bank_sel]));
            chk("exec_cnt", 32'(exec_cnt), 32'(m_exec));
            chk("squash_cnt", 32'(squash_cnt), 32'(m_squash));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic e, input logic [3:0] c, input logic [3:0] af,
                          input logic [1:0] fw, input logic p, input logic rw,
                          input logic mw, input logic nw, input logic bs,
                          input logic clr);
        en = e; cond = c; alu_flags = af; flag_w = fw; pcs = p; reg_w = rw;
        mem_w = mw; no_write = nw; bank_sel = bs; cnt_clr = clr;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Writes the full nibble into bank bs with an AL instruction.
    task automatic write_flags(input logic [3:0] f, input logic bs);
        set_in(1, 4'hE, f, 2'b11, 0, 0, 0, 0, bs, 0);
        step();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic check_flags(input string name);
        logic [3:0] e;
        e = exp_q.pop_front();
        chk(name, 32'(flags_o), 32'(e));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);

        // Reset with no clock running.
        #2;
        chk("rst_flags", 32'(flags_o), 32'h0);
        set_in(0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("rst_eq", 32'(cond_ex), 32'h0);
        set_in(0, 4'h1, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
        chk("rst_ne", 32'(cond_ex), 32'h1);
        chk("rst_exec", 32'(exec_cnt), 32'h0);
        chk("rst_squash", 32'(squash_cnt), 32'h0);

        rst_n = 1'b1;
        #2;
        clk_run = 1'b1;
        step();
        chk_on = 1'b1;

        // All 16 flag values x all 16 codes in bank 0.
        for (int f = 0; f < 16; f++) begin
            write_flags(4'(f), 0);
            for (int c = 0; c < 16; c++) begin
                set_in(0, 4'(c), 4'h0, 2'b00, 1, 1, 1, 0, 0, 0);
                chk("tbl", 32'(cond_ex), 32'(model_pass(4'(c), 4'(f))));
                step();
            end
        end

        // Literal pins on the table.
        write_flags(4'b0110, 0);
        set_in(0, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0); chk("hi_0110", 32'(cond_ex), 32'h0);
        set_in(0, 4'h9, 0, 0, 0, 0, 0, 0, 0, 0); chk("ls_0110", 32'(cond_ex), 32'h1);
        set_in(0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0); chk("f_0110", 32'(cond_ex), 32'h1);
        write_flags(4'b1000, 0);
        set_in(0, 4'hA, 0, 0, 0, 0, 0, 0, 0, 0); chk("ge_1000", 32'(cond_ex), 32'h0);
        set_in(0, 4'hB, 0, 0, 0, 0, 0, 0, 0, 0); chk("lt_1000", 32'(cond_ex), 32'h1);
        set_in(0, 4'hC, 0, 0, 0, 0, 0, 0, 0, 0); chk("gt_1000", 32'(cond_ex), 32'h0);
        set_in(0, 4'hD, 0, 0, 0, 0, 0, 0, 0, 0); chk("le_1000", 32'(cond_ex), 32'h1);
        step();

        // Predicated flag write.
        reset_pulse();
        set_in(1, 4'h0, 4'hF, 2'b11, 1, 1, 1, 0, 0, 0);
        chk("eq_fail_regw", 32'(reg_w_o), 32'h0);
        chk("eq_fail_cex", 32'(cond_ex), 32'h0);
        step();
        exp_q.push_back(4'h0); check_flags("eq_no_write");
        set_in(1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 0, 0);
        chk("al_regw", 32'(reg_w_o), 32'h1);
        step();
        exp_q.push_back(4'hF); check_flags("al_write");

        // Group write and stall.
        write_flags(4'b1010, 0);
        set_in(1, 4'hE, 4'b0101, 2'b10, 0, 0, 0, 0, 0, 0);
        step();
        exp_q.push_back(4'b0110); check_flags("nz_only");
        set_in(0, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 0, 0);
        chk("stall_pcs", 32'(pcs_o), 32'h0);
        chk("stall_regw", 32'(reg_w_o), 32'h0);
        chk("stall_memw", 32'(mem_w_o), 32'h0);
        step();
        exp_q.push_back(4'b0110); check_flags("stall_hold");

        // Banks.
        reset_pulse();
        write_flags(4'b1000, 0);
        set_in(0, 4'hE, 0, 0, 0, 0, 0, 0, 1, 0);
        exp_q.push_back(4'b0000); check_flags("bank1_clean");
        write_flags(4'b0100, 1);
        set_in(0, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(4'b1000); check_flags("bank0_kept");
        set_in(0, 4'hE, 0, 0, 0, 0, 0, 0, 1, 0);
        exp_q.push_back(4'b0100); check_flags("bank1_kept");
        rst_n = 1'b0;
        #1;
        chk("midrst_b1", 32'(flags_o), 32'h0);
        set_in(0, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("midrst_b0", 32'(flags_o), 32'h0);
        rst_n = 1'b1;
        #1;
        step();

        // Counters.
        reset_pulse();
        for (int i = 0; i < 20; i++) begin
            set_in(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
            step();
        end
`ifdef CLU_PERF_CNT_EN
        chk("exec_sat", 32'(exec_cnt), 32'd15);
`else
        chk("exec_off", 32'(exec_cnt), 32'd0);
`endif
        for (int i = 0; i < 3; i++) begin
            set_in(1, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
            step();
        end
`ifdef CLU_PERF_CNT_EN
        chk("squash_3", 32'(squash_cnt), 32'd3);
`else
        chk("squash_off", 32'(squash_cnt), 32'd0);
`endif
        set_in(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
        step();
        chk("clr_exec", 32'(exec_cnt), 32'd0);
        chk("clr_squash", 32'(squash_cnt), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
            step();
        end

        // Final report.
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
